// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and response bundle for alu_op_sequencer.
// The slave side is the sequencer; the master side is the issue stage plus the ALU.
interface alu_op_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_opcode;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [TAG_W-1:0] req_tag;

   logic [1:0]       alu_opcode;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_y;
   logic             alu_zero;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_y;
   logic             rsp_zero;
   logic [TAG_W-1:0] rsp_tag;

   modport master (
      output req_valid, req_opcode, req_a, req_b, req_tag,
      output alu_y, alu_zero,
      output rsp_ready,
      input  req_ready,
      input  alu_opcode, alu_a, alu_b,
      input  rsp_valid, rsp_y, rsp_zero, rsp_tag
   );

   modport slave (
      input  req_valid, req_opcode, req_a, req_b, req_tag,
      input  alu_y, alu_zero,
      input  rsp_ready,
      output req_ready,
      output alu_opcode, alu_a, alu_b,
      output rsp_valid, rsp_y, rsp_zero, rsp_tag
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Buffers ALU requests in a FIFO, feeds the head to the ALU and
// registers the result into a tagged valid/ready response.
module alu_op_sequencer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   alu_op_sequencer_if.slave bus,
   output logic              busy,
   output logic [15:0]       op_count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [1:0]       opcode;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      occ;
   logic             full;
   logic             empty;
   logic             push;
   logic             issue;

   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_y;
   logic             rsp_zero;
   logic [TAG_W-1:0] rsp_tag;
   logic [15:0]      cnt;

   assign full  = (occ == FULL_CNT);
   assign empty = (occ == '0);

   // Ready depends only on occupancy, so there is no path from rsp_ready.
   assign push  = bus.req_valid && !full;
   assign issue = !empty && (!rsp_valid || bus.rsp_ready);

   assign head = mem[rd_ptr];

   always_comb begin
      bus.alu_opcode = '0;
      bus.alu_a      = '0;
      bus.alu_b      = '0;
      if (!empty) begin
         bus.alu_opcode = head.opcode;
         bus.alu_a      = head.a;
         bus.alu_b      = head.b;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{
            opcode: bus.req_opcode,
            a:      bus.req_a,
            b:      bus.req_b,
            tag:    bus.req_tag
         };
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (issue) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, issue})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
         rsp_zero  <= 1'b0;
         rsp_tag   <= '0;
         cnt       <= '0;
      end else if (issue) begin
         rsp_valid <= 1'b1;
         rsp_y     <= bus.alu_y;
         rsp_zero  <= bus.alu_zero;
         rsp_tag   <= head.tag;
         cnt       <= cnt + 16'd1;
      end else if (rsp_valid && bus.rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   assign bus.req_ready = !full;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_y     = rsp_y;
   assign bus.rsp_zero  = rsp_zero;
   assign bus.rsp_tag   = rsp_tag;

   assign busy     = !empty || rsp_valid;
   assign op_count = cnt;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [15:0] op_count;

   always #5 clk = ~clk;

   alu_op_sequencer_if #(.WIDTH(32), .TAG_W(4)) bus ();

   alu_op_sequencer #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .busy     (busy),
      .op_count (op_count)
   );

   typedef struct {
      logic [31:0] y;
      logic        zero;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [31:0] ref_alu(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a | b;
      endcase
   endfunction

   always_comb begin
      bus.alu_y    = ref_alu(bus.alu_opcode, bus.alu_a, bus.alu_b);
      bus.alu_zero = (bus.alu_y == 32'd0);
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops on each transfer, and checks stall stability.
   logic        hold_chk = 1'b0;
   logic [31:0] prev_y;
   logic        prev_zero;
   logic [3:0]  prev_tag;

   always @(negedge clk) begin
      if (rst) begin
         hold_chk = 1'b0;
      end else begin
         if (hold_chk) begin
            chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_y", bus.rsp_y, prev_y);
            chk("stall_zero", 32'(bus.rsp_zero), 32'(prev_zero));
            chk("stall_tag", 32'(bus.rsp_tag), 32'(prev_tag));
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_y", bus.rsp_y, e.y);
               chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
               chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
            end
         end
         hold_chk  = bus.rsp_valid && !bus.rsp_ready;
         prev_y    = bus.rsp_y;
         prev_zero = bus.rsp_zero;
         prev_tag  = bus.rsp_tag;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] ey, input logic ez);
      int   n;
      exp_t e;
      bus.req_valid  = 1'b1;
      bus.req_opcode = op;
      bus.req_a      = a;
      bus.req_b      = b;
      bus.req_tag    = tag;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.req_ready) break;
         @(posedge clk);
         #1;
         n++;
         if (n > 50) begin
            chk("push_timeout", 32'd1, 32'd0);
            bus.req_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      e.y    = ey;
      e.zero = ez;
      e.tag  = tag;
      sb.push_back(e);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic push_ref(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag);
      logic [31:0] y;
      y = ref_alu(op, a, b);
      push(op, a, b, tag, y, y == 32'd0);
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.rsp_valid) && n < max) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      #1;
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cycles;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_opcode = 2'd0;
      bus.req_a      = 32'd0;
      bus.req_b      = 32'd0;
      bus.req_tag    = 4'd0;
      bus.rsp_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_y", bus.rsp_y, 32'd0);
      chk("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
      chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single op and first-response latency
      push(2'd0, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
      chk("lat_rsp_valid_n", 32'(bus.rsp_valid), 32'd0);
      chk("lat_busy", 32'(busy), 32'd1);
      chk("lat_alu_a", bus.alu_a, 32'd5);
      chk("lat_alu_b", bus.alu_b, 32'd7);
      @(posedge clk);
      #1;
      chk("lat_rsp_valid_n1", 32'(bus.rsp_valid), 32'd1);
      chk("single_op_count", 32'(op_count), 32'd1);
      drain(20);

      // zero flag and operand order
      push(2'd1, 32'd9, 32'd9, 4'd5, 32'd0, 1'b1);
      push(2'd3, 32'd0, 32'd0, 4'd6, 32'd0, 1'b1);
      push(2'd2, 32'h0000_F0F0, 32'h0000_0FF0, 4'd7, 32'h0000_00F0, 1'b0);
      push(2'd1, 32'd3, 32'd5, 4'd8, 32'hFFFF_FFFE, 1'b0);
      drain(20);
      chk("zero_op_count", 32'(op_count), 32'd5);

      // back-pressure: one in the response register, four in the FIFO
      bus.rsp_ready = 1'b0;
      push(2'd0, 32'd1, 32'd2, 4'd1, 32'd3, 1'b0);
      push(2'd1, 32'd10, 32'd4, 4'd2, 32'd6, 1'b0);
      push(2'd2, 32'hFF, 32'h0F, 4'd3, 32'h0F, 1'b0);
      push(2'd3, 32'hA0, 32'h05, 4'd4, 32'hA5, 1'b0);
      push(2'd0, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd0, 1'b1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_hold_tag", 32'(bus.rsp_tag), 32'd1);
      chk("bp_hold_y", bus.rsp_y, 32'd3);
      chk("bp_op_count", 32'(op_count), 32'd6);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_still_full", 32'(bus.req_ready), 32'd0);
      bus.rsp_ready = 1'b1;
      cycles = 0;
      while (sb.size() != 0 && cycles < 20) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      chk("bp_release_cycles", 32'(cycles), 32'd5);
      @(posedge clk);
      #1;
      chk("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
      chk("bp_after_busy", 32'(busy), 32'd0);
      chk("bp_after_op_count", 32'(op_count), 32'd10);

      // streaming 100 ops back to back
      do_reset();
      for (int i = 0; i < 100; i++) begin
         logic [31:0] iv;
         iv = 32'(i);
         push_ref(iv[1:0], iv * 32'd7 + 32'd3, (iv * 32'd13) ^ 32'h55, iv[3:0]);
      end
      drain(20);
      chk("stream_op_count", 32'(op_count), 32'd100);

      // counter wrap and long pointer wrap
      do_reset();
      for (int i = 0; i < 65537; i++) begin
         logic [31:0] iv;
         iv = 32'(i);
         push_ref(iv[1:0], iv ^ 32'h1234_5678, iv << 3, iv[7:4]);
      end
      drain(20);
      chk("wrap_op_count", 32'(op_count), 32'd1);

      // reset mid-operation
      bus.rsp_ready = 1'b0;
      push(2'd0, 32'd1, 32'd1, 4'd1, 32'd2, 1'b0);
      push(2'd0, 32'd2, 32'd2, 4'd2, 32'd4, 1'b0);
      push(2'd0, 32'd3, 32'd3, 4'd3, 32'd6, 1'b0);
      push(2'd0, 32'd4, 32'd4, 4'd4, 32'd8, 1'b0);
      chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_count", 32'(op_count), 32'd0);
      sb.delete();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      push(2'd0, 32'd20, 32'd22, 4'd9, 32'd42, 1'b0);
      drain(20);
      chk("post_rst_count", 32'(op_count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
